// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types and constants for the instruction fetch stage
package fetch_stage_pkg;

    // One buffered fetch result: the PC it was read from and the word returned.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: redirect, instruction-memory and decode handshake signals of the fetch stage
//   redirect_valid/redirect_pc : backend redirect request and target
//   imem_en/imem_addr          : read request toward 1-cycle-latency instruction memory
//   imem_rdata                 : read data, valid one cycle after imem_en
//   valid_out/ready_out        : valid/ready handshake toward decode
//   instr_out/pc_out           : instruction and its PC at the FIFO head
//   master = fetch stage side, slave = environment (memory, decode, backend)
interface fetch_stage_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, ready_out,
        output imem_en, imem_addr, valid_out, instr_out, pc_out
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, ready_out,
        input  imem_en, imem_addr, valid_out, instr_out, pc_out
    );
endinterface

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_data with push/pop/flush
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write an entry
//   pop        : discard the head entry (ignored when empty)
//   flush      : drop all entries and reset the pointers
//   dout       : head entry, combinational
//   count      : number of entries held
//   empty/full : occupancy flags
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_data                din,
    output fetch_data                dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_data       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            pop_ok;

    always_comb begin
        pop_ok = pop & !empty;
        empty  = count == '0;
        full   = count == CW'(DEPTH);
        dout   = mem[rd_ptr];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing word reads to a 1-cycle imem and buffering {pc, instr} for decode
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_stage_if.master (redirect, imem request/data, decode valid/ready)
//   Optional macro FETCH_STATS_EN adds saturating counters:
//     stat_fetched (pops), stat_stall (valid_out & !ready_out cycles), stat_flush (redirects)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]   stat_fetched,
    output logic [31:0]   stat_stall,
    output logic [15:0]   stat_flush
`endif
);
    // One extra bit over the count so count + inflight cannot overflow.
    localparam int CW = $clog2(DEPTH) + 2;

    logic [31:0]            pc_q;
    logic [31:0]            inflight_pc;
    logic                   inflight_q;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [CW-1:0]          credit;
    fetch_data              head;
    fetch_data              ret;

    // Credit counts buffered entries plus the read still in flight, minus
    // what decode takes this cycle; issuing only below DEPTH guarantees
    // every return finds room in the FIFO.
    always_comb begin
        pop    = bus.valid_out & bus.ready_out;
        push   = inflight_q & !bus.redirect_valid;
        credit = CW'(count) + CW'(inflight_q) - CW'(pop);
        issue  = !reset & !bus.redirect_valid & (credit < CW'(DEPTH));
        ret    = '{pc: inflight_pc, instr: bus.imem_rdata};
    end

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q;
    assign bus.valid_out = !empty;
    assign bus.instr_out = head.instr;
    assign bus.pc_out    = head.pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight_q <= issue;
            if (issue)
                inflight_pc <= pc_q;
            if (bus.redirect_valid)
                pc_q <= align_pc(bus.redirect_pc);
            else if (issue)
                pc_q <= pc_q + PC_STEP;
        end
    end

    // A redirect flushes the FIFO; a same-cycle pop has already been handed to decode.
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (ret),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(push && full && !pop)) else $error("fetch fifo overflow");
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
            stat_flush   <= '0;
        end else begin
            stat_fetched <= stat_fetched + 32'(pop && !(&stat_fetched));
            stat_stall   <= stat_stall + 32'(bus.valid_out && !bus.ready_out && !(&stat_stall));
            stat_flush   <= stat_flush + 16'(bus.redirect_valid && !(&stat_flush));
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage (imem returns ~addr as data)
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    fetch_stage_if bus();

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_stall;
    logic [15:0] stat_flush;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_stall   (stat_stall),
        .stat_flush   (stat_flush)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.imem_rdata <= bus.imem_en ? ~bus.imem_addr : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step after the releasing edge, i.e. cycle 0 of the new run.
    task automatic restart(input logic rdy);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.ready_out = rdy;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.ready_out = 1'b1;
        tick;
        tick;
        #1;
        check("rst_valid", bus.valid_out, 0);
        check("rst_en", bus.imem_en, 0);
        check("rst_addr", bus.imem_addr, 32'h0);

        // 1: streaming from reset, 2-cycle latency
        reset = 1'b0;
        #1;
        check("t1_en0", bus.imem_en, 1);
        check("t1_addr0", bus.imem_addr, 32'h0);
        check("t1_valid0", bus.valid_out, 0);
        tick; #1;
        check("t1_valid1", bus.valid_out, 0);
        check("t1_addr1", bus.imem_addr, 32'h4);
        tick; #1;
        check("t1_valid2", bus.valid_out, 1);
        check("t1_pc2", bus.pc_out, 32'h0);
        check("t1_instr2", bus.instr_out, 32'hFFFF_FFFF);
        tick; #1;
        check("t1_pc3", bus.pc_out, 32'h4);
        check("t1_instr3", bus.instr_out, 32'hFFFF_FFFB);
        tick; #1;
        check("t1_pc4", bus.pc_out, 32'h8);

        // 2: backpressure fills the FIFO, then drains at 1/cycle
        restart(1'b0);
        repeat (5) tick;
        #1;
        check("t2_valid", bus.valid_out, 1);
        check("t2_pc", bus.pc_out, 32'h0);
        check("t2_en", bus.imem_en, 0);
        check("t2_addr", bus.imem_addr, 32'h10);
        tick; tick; #1;
        check("t2_hold_pc", bus.pc_out, 32'h0);
        check("t2_hold_en", bus.imem_en, 0);
        bus.ready_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_drain_valid", bus.valid_out, 1);
            check("t2_drain_pc", bus.pc_out, 32'(i * 4));
            check("t2_drain_instr", bus.instr_out, ~32'(i * 4));
            tick;
        end

        // 3: redirect with 3 buffered and one in flight
        restart(1'b0);
        repeat (4) tick;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h103;
        #1;
        check("t3_en_redir", bus.imem_en, 0);
        check("t3_pc_redir", bus.pc_out, 32'h0);
        tick;
        bus.redirect_valid = 1'b0;
        #1;
        check("t3_valid5", bus.valid_out, 0);
        check("t3_en5", bus.imem_en, 1);
        check("t3_addr5", bus.imem_addr, 32'h100);
        tick; #1;
        check("t3_valid6", bus.valid_out, 0);
        tick; #1;
        check("t3_valid7", bus.valid_out, 1);
        check("t3_pc7", bus.pc_out, 32'h100);
        check("t3_instr7", bus.instr_out, ~32'h100);

        // 4: redirect together with pop and an arriving return
        restart(1'b0);
        repeat (4) tick;
        bus.ready_out = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        #1;
        check("t4_pop_valid", bus.valid_out, 1);
        check("t4_pop_pc", bus.pc_out, 32'h0);
        tick;
        bus.redirect_valid = 1'b0;
        #1;
        check("t4_empty5", bus.valid_out, 0);
        check("t4_addr5", bus.imem_addr, 32'h200);
        tick; #1;
        check("t4_empty6", bus.valid_out, 0);
        tick; #1;
        check("t4_pc7", bus.pc_out, 32'h200);
        check("t4_valid7", bus.valid_out, 1);
        tick; #1;
        check("t4_pc8", bus.pc_out, 32'h204);

        // 5: PC wrap at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick;
        bus.redirect_valid = 1'b0;
        tick;
        tick;
        #1;
        check("t5_pc_top", bus.pc_out, 32'hFFFF_FFFC);
        check("t5_instr_top", bus.instr_out, 32'h3);
        tick; #1;
        check("t5_pc_wrap", bus.pc_out, 32'h0);
        check("t5_instr_wrap", bus.instr_out, 32'hFFFF_FFFF);
        tick; #1;
        check("t5_pc_next", bus.pc_out, 32'h4);

`ifdef FETCH_STATS_EN
        // 6: 2 redirects, 10 pops, 3 stall cycles, then reset clears
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.ready_out = 1'b0;
        tick;
        tick;
        #1;
        check("t6_rst_fetched", stat_fetched, 0);
        reset = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        tick;
        tick;
        bus.redirect_valid = 1'b0;
        bus.ready_out = 1'b1;
        tick;
        tick;
        #1;
        check("t6_first_pc", bus.pc_out, 32'h40);
        repeat (10) tick;
        bus.ready_out = 1'b0;
        repeat (3) tick;
        #1;
        check("t6_fetched", stat_fetched, 32'd10);
        check("t6_stall", stat_stall, 32'd3);
        check("t6_flush", 32'(stat_flush), 32'd2);
        reset = 1'b1;
        tick;
        #1;
        check("t6_clr_fetched", stat_fetched, 0);
        check("t6_clr_stall", stat_stall, 0);
        check("t6_clr_flush", 32'(stat_flush), 0);
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
